dmem_arbiter: RTL and testbench

- Single-clock arbiter that shares one single-port synchronous data memory (D_Mem-style, 512 x 32) between NREQ requesters, e.g. the core MEM stage, a program/data loader and a debug port.
- Grants at most one access per cycle, drives the memory port, and returns read data tagged to the issuing requester after a fixed memory latency.
- Supports round-robin or fixed-priority mode, with starvation promotion in fixed mode.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter_rr_pick.sv | 28 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared limits, priority-mode enum and one-hot decode for the data-memory arbiter
package dmem_arb_pkg;
    localparam int MAX_NREQ   = 8;
    localparam int MAX_RD_LAT = 4;
    localparam int IDW        = $clog2(MAX_NREQ);

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

    function automatic logic [IDW-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) idx |= oh[i] ? IDW'(i) : '0;
        return idx;
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the shared data-memory arbiter
interface dmem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 9,
    parameter int DW   = 32
);
    logic                 prio_mode;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    modport master (
        output prio_mode, req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  prio_mode, req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: one-hot pick of the first set request at or after a start index, wrapping around
module rr_pick #(
    parameter int N  = 2,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_start,
    output logic [N-1:0]  o_gnt
);
    // rank every requester by its rotated distance from the start and keep the nearest
    always_comb begin
        int best;
        int best_d;
        int d;
        best   = 0;
        best_d = N;
        d      = 0;
        o_gnt  = '0;
        for (int j = 0; j < N; j++) begin
            d = (j >= int'(i_start)) ? j - int'(i_start) : j + N - int'(i_start);
            if (i_req[j] && d < best_d) begin
                best   = j;
                best_d = d;
            end
        end
        for (int j = 0; j < N; j++) o_gnt[j] = (best_d < N) && (best == j);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between NREQ requesters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 9,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input logic           clk_1,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("dmem_arbiter: NREQ out of range");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("dmem_arbiter: RD_LAT out of range");
    end
    if (MAX_WAIT < 1) begin : g_bad_wait
        $error("dmem_arbiter: MAX_WAIT must be at least 1");
    end

    logic [PW-1:0]  r_ptr;
    logic [CW-1:0]  r_cnt    [NREQ];
    logic           r_tag_v  [RD_LAT];
    logic [IDW-1:0] r_tag_id [RD_LAT];

    logic [NREQ-1:0] w_urgent;
    logic [NREQ-1:0] w_gnt_urg;
    logic [NREQ-1:0] w_gnt_rr;
    logic [NREQ-1:0] w_gnt_fix;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_rd;

    // a requester is urgent once it has been denied MAX_WAIT cycles in a row and still asks
    always_comb begin
        w_urgent = '0;
        for (int i = 0; i < NREQ; i++) w_urgent[i] = bus.req[i] && (r_cnt[i] == CW'(MAX_WAIT));
    end

    rr_pick #(.N(NREQ)) u_pick_urg (
        .i_req   (w_urgent),
        .i_start (PW'(0)),
        .o_gnt   (w_gnt_urg)
    );

    rr_pick #(.N(NREQ)) u_pick_rr (
        .i_req   (bus.req),
        .i_start (r_ptr),
        .o_gnt   (w_gnt_rr)
    );

    rr_pick #(.N(NREQ)) u_pick_fix (
        .i_req   (bus.req),
        .i_start (PW'(0)),
        .o_gnt   (w_gnt_fix)
    );

    // grant selection (urgent, then mode order, nothing in reset) and memory-port mux
    always_comb begin
        w_gnt = rst ? '0
              : (|w_urgent) ? w_gnt_urg
              : (prio_mode_e'(bus.prio_mode) == PRIO_RR) ? w_gnt_rr
              : w_gnt_fix;
        w_idx         = onehot_to_idx(MAX_NREQ'(w_gnt));
        bus.gnt       = w_gnt;
        bus.mem_en    = |w_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                bus.mem_we    = bus.we[i];
                bus.mem_addr  = bus.addr[i*AW +: AW];
                bus.mem_wdata = bus.wdata[i*DW +: DW];
            end
        end
        w_rd = bus.mem_en && !bus.mem_we;
    end

    // round-robin pointer, saturating wait counters and the read-tag delay line
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_tag_v[k]  <= 1'b0;
                r_tag_id[k] <= '0;
            end
        end else begin
            if (|w_gnt) r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : PW'(w_idx + IDW'(1));
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= (!bus.req[i] || w_gnt[i]) ? '0
                          : (r_cnt[i] == CW'(MAX_WAIT)) ? r_cnt[i]
                          : r_cnt[i] + CW'(1);
            end
            r_tag_v[0]  <= w_rd;
            r_tag_id[0] <= w_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // oldest tag steers the memory's read data to the requester that issued the read
    always_comb begin
        bus.rvalid = (r_tag_v[RD_LAT-1] && !rst) ? NREQ'(1) << r_tag_id[RD_LAT-1] : '0;
        bus.rdata  = bus.mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench with a behavioural arbitration and memory model
module tb_dmem_arbiter;
    localparam int N        = 3;
    localparam int AW       = 9;
    localparam int DW       = 32;
    localparam int RD_LAT   = 3;
    localparam int MAX_WAIT = 3;

    typedef struct {
        int             due;
        int             id;
        logic [DW-1:0]  data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(
        .NREQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_1 (clk),
        .rst   (rst),
        .bus   (bus)
    );

    rd_t            q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    bit             mon_on;
    logic [DW-1:0]  shadow [512];
    logic           pend [N];
    logic           pwe  [N];
    logic [AW-1:0]  paddr [N];
    logic [DW-1:0]  pwd  [N];
    int             ptr;
    int             cnt [N];
    logic           mode;
    logic [N-1:0]   seen;
    logic [N-1:0]   mon_ev;

    // environment memory: writes land on the edge, reads return RD_LAT cycles later
    logic [DW-1:0]  mem   [512];
    logic [DW-1:0]  rpipe [RD_LAT];
    bit             mem_init;

    function automatic logic [DW-1:0] init_val(int a);
        return (a == 5) ? 32'hDEADBEEF : (32'(a) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        rpipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : '0;
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign bus.mem_rdata = rpipe[RD_LAT-1];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        bus.prio_mode = mode;
        for (int i = 0; i < N; i++) begin
            bus.req[i]            = pend[i];
            bus.we[i]             = pwe[i];
            bus.addr[i*AW +: AW]  = paddr[i];
            bus.wdata[i*DW +: DW] = pwd[i];
        end
    endtask

    task automatic issue(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        pend[i]  = 1'b1;
        pwe[i]   = w;
        paddr[i] = a;
        pwd[i]   = d;
    endtask

    task automatic issue_rand(int i);
        issue(i, 1'($urandom % 2), AW'($urandom % 16), $urandom);
    endtask

    // reference arbitration: urgent lowest index, else rotating or fixed order
    function automatic int pick();
        for (int i = 0; i < N; i++) if (pend[i] && cnt[i] >= MAX_WAIT) return i;
        if (!mode) begin
            for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end else begin
            for (int i = 0; i < N; i++) if (pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic cycle_check();
        int g;
        logic [N-1:0] eg;
        g  = rst ? -1 : pick();
        eg = (g >= 0) ? N'(1) << g : '0;
        seen = bus.gnt;
        chk("gnt", 64'(bus.gnt), 64'(eg));
        chk("mem_en", 64'(bus.mem_en), 64'(g >= 0));
        if (g >= 0) begin
            chk("mem_we", 64'(bus.mem_we), 64'(pwe[g]));
            chk("mem_addr", 64'(bus.mem_addr), 64'(paddr[g]));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(pwd[g]));
        end else begin
            chk("idle_we", 64'(bus.mem_we), 64'(0));
            chk("idle_addr", 64'(bus.mem_addr), 64'(0));
            chk("idle_wdata", 64'(bus.mem_wdata), 64'(0));
        end
        if (rst) begin
            ptr = 0;
            cnt = '{default: 0};
            q.delete();
        end else begin
            for (int i = 0; i < N; i++)
                cnt[i] = (!pend[i] || i == g) ? 0 : (cnt[i] < MAX_WAIT ? cnt[i] + 1 : MAX_WAIT);
            if (g >= 0) begin
                ptr = (g + 1) % N;
                if (!pwe[g]) q.push_back('{cyc + RD_LAT, g, shadow[paddr[g]]});
                else shadow[paddr[g]] = pwd[g];
                pend[g] = 1'b0;
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        #2;
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic renew(int i);
        if (!pend[i]) issue_rand(i);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    // scoreboard monitor: every cycle the oldest due read must appear, otherwise rvalid stays low
    always @(negedge clk) begin
        if (mon_on) begin
            mon_ev = '0;
            if (q.size() > 0 && q[0].due == cyc) mon_ev = N'(1) << q[0].id;
            chk("rvalid", 64'(bus.rvalid), 64'(mon_ev));
            if (mon_ev != '0) begin
                chk("rdata", 64'(bus.rdata), 64'(q[0].data));
                void'(q.pop_front());
            end
        end
    end

    localparam logic [N-1:0] STARVE [8] = '{3'b001, 3'b001, 3'b001, 3'b010,
                                           3'b001, 3'b001, 3'b001, 3'b010};

    initial begin
        mode = 1'b0;
        ptr  = 0;
        cnt  = '{default: 0};
        for (int i = 0; i < N; i++) issue(i, 1'b0, '0, '0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int i = 0; i < 512; i++) shadow[i] = init_val(i);
        drive();
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        issue(0, 1'b0, 9'h020, '0);
        issue(1, 1'b0, 9'h021, '0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_gnt", 64'(seen), 64'(0));
        end
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            renew(0);
            renew(1);
            step();
            chk("rr_seq", 64'(seen), 64'((k % 2) ? 3'b010 : 3'b001));
        end
        pend[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            renew(1);
            step();
            chk("rr_single", 64'(seen), 64'(3'b010));
        end

        idle(1);
        issue(1, 1'b0, 9'h005, '0);
        step();
        chk("rd_gnt", 64'(seen), 64'(3'b010));
        idle(RD_LAT + 1);

        issue(0, 1'b1, 9'h007, 32'h12345678);
        step();
        chk("wr_gnt", 64'(seen), 64'(3'b001));
        issue(1, 1'b0, 9'h007, '0);
        step();
        chk("rd7_gnt", 64'(seen), 64'(3'b010));
        idle(RD_LAT + 1);

        mode = 1'b1;
        idle(1);
        for (int k = 0; k < 8; k++) begin
            renew(0);
            renew(1);
            step();
            chk("starve", 64'(seen), 64'(STARVE[k]));
        end

        mode = 1'b0;
        idle(RD_LAT + 1);
        issue(1, 1'b0, 9'h003, '0);
        step();
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        idle(RD_LAT + 1);

        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom % 150 == 0);
            if (rst) q.delete();
            if ($urandom % 40 == 0) mode = ~mode;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom % 3 == 0) issue_rand(i);
                end else if ($urandom % 25 == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step();
        end
        rst = 1'b0;
        idle(RD_LAT + 3);
        chk("drain", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
